// File: rtl/operand_fetch_unit_pkg.sv
// Shared constants and helpers for the operand fetch / issue stage.
// Field positions assume the fixed two-operand format (rs is also dest).
package operand_fetch_unit_pkg;

  localparam int NREG_D     = 32;
  localparam int AW_D       = 5;
  localparam int DW_D       = 32;
  localparam int STALL_CW_D = 16;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  function automatic logic [NREG_D-1:0] onehot(
    input logic [AW_D-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/operand_fetch_unit_scoreboard.sv
// Per-register in-flight write tracker with two combinational lookups.
// A set on the same index as a clear wins: the new owner is pending.
import operand_fetch_unit_pkg::*;

module reg_scoreboard #(
  parameter int NREG = NREG_D,
  parameter int AW   = AW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  output logic          ebusy_a,
  output logic          ebusy_b
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] ebusy;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec = NREG'(onehot(AW_D'(set_idx)));
    if (clr_en) clr_vec = NREG'(onehot(AW_D'(clr_idx)));
  end

  assign ebusy   = busy & ~clr_vec;
  assign ebusy_a = ebusy[rd_a];
  assign ebusy_b = ebusy[rd_b];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= ebusy | set_vec;
    end
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch / issue stage: bank read, write bypass, hazard stall,
// and a single-entry output register toward execute.
import operand_fetch_unit_pkg::*;

module operand_fetch_unit #(
  parameter int NREG     = NREG_D,
  parameter int AW       = AW_D,
  parameter int DW       = DW_D,
  parameter int STALL_CW = STALL_CW_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_instr,
  input  logic [DW-1:0]       in_pc,
  input  logic                in_wr_en,
  output logic [AW-1:0]       read_rs,
  output logic [AW-1:0]       read_rt,
  input  logic [DW-1:0]       rs_data,
  input  logic [DW-1:0]       rt_data,
  input  logic                wb_enable,
  input  logic [AW-1:0]       wb_loc,
  input  logic [DW-1:0]       wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_instr,
  output logic [DW-1:0]       out_pc,
  output logic [DW-1:0]       out_rs_val,
  output logic [DW-1:0]       out_rt_val,
  output logic                out_wr_en,
  output logic [STALL_CW-1:0] stall_cnt
);

  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          ebusy_a;
  logic          ebusy_b;
  logic          hazard;
  logic          issue;

  assign rs      = in_instr[RS_MSB:RS_LSB];
  assign rt      = in_instr[RT_MSB:RT_LSB];
  assign read_rs = rs;
  assign read_rt = rt;

  // Bank write this cycle is not yet visible on the read ports.
  assign op_a = (wb_enable && wb_loc == rs) ? wb_data : rs_data;
  assign op_b = (wb_enable && wb_loc == rt) ? wb_data : rt_data;

  reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .set_en  (issue & in_wr_en),
    .set_idx (rs),
    .clr_en  (wb_enable),
    .clr_idx (wb_loc),
    .rd_a    (rs),
    .rd_b    (rt),
    .ebusy_a (ebusy_a),
    .ebusy_b (ebusy_b)
  );

  assign hazard   = in_valid & (ebusy_a | ebusy_b);
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign issue    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_wr_en  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_instr  <= in_instr;
      out_pc     <= in_pc;
      out_rs_val <= op_a;
      out_rt_val <= op_b;
      out_wr_en  <= in_wr_en;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + STALL_CW'(1);
    end
  end

endmodule
